calc_sequencer: RTL



---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_sequencer.sv | 101 ++++++++++
 2 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front-end: opcodes, sequencer states
// and the default datapath width.
package calc_pkg;

   localparam int CALC_W = 4;

   localparam logic [2:0] OP_ADD_AB = 3'b000;
   localparam logic [2:0] OP_SUB_AB = 3'b001;
   localparam logic [2:0] OP_ABS_B  = 3'b010;
   localparam logic [2:0] OP_ADD_BA = 3'b100;
   localparam logic [2:0] OP_SUB_BA = 3'b101;
   localparam logic [2:0] OP_ABS_A  = 3'b110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/calc_sequencer.sv
// Command front-end for the combinational calculator: registers the operands,
// captures the result one cycle later, and keeps an accumulator, sticky overflow and op counter.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int W     = CALC_W,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; a producer holds its payload stable until that edge.
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic             cmd_acc_sel,
   input  logic [W-1:0]     cmd_a,
   input  logic [W-1:0]     cmd_b,
   input  logic             cmd_clr,
   output logic [2:0]       calc_op,
   output logic [W-1:0]     calc_a,
   output logic [W-1:0]     calc_b,
   input  logic [W-1:0]     calc_r,
   input  logic             calc_ovf,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [W-1:0]     rsp_r,
   output logic             rsp_ovf,
   output logic [W-1:0]     acc,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] op_count,
   output state_t           dbg_state
);

   state_t           state_q;
   logic [2:0]       calc_op_q;
   logic [W-1:0]     calc_a_q, calc_b_q;
   logic [W-1:0]     rsp_r_q, acc_q;
   logic             rsp_ovf_q, sticky_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         calc_op_q <= '0;
         calc_a_q  <= '0;
         calc_b_q  <= '0;
         rsp_r_q   <= '0;
         rsp_ovf_q <= 1'b0;
         acc_q     <= '0;
         sticky_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_clr) begin
                     // Clear takes priority over whatever opcode rides along.
                     acc_q     <= '0;
                     sticky_q  <= 1'b0;
                     rsp_r_q   <= '0;
                     rsp_ovf_q <= 1'b0;
                     state_q   <= RESP;
                  end else begin
                     calc_op_q <= cmd_op;
                     calc_a_q  <= cmd_acc_sel ? acc_q : cmd_a;
                     calc_b_q  <= cmd_b;
                     state_q   <= EXEC;
                  end
               end
            end
            EXEC: begin
               rsp_r_q   <= calc_r;
               rsp_ovf_q <= calc_ovf;
               acc_q     <= calc_r;
               sticky_q  <= sticky_q | calc_ovf;
               if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
               state_q   <= RESP;
            end
            RESP: begin
               if (rsp_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Gated by rst_n so every output reads 0 while reset is held.
   assign cmd_ready  = (state_q == IDLE) && rst_n;
   assign rsp_valid  = (state_q == RESP);
   assign calc_op    = calc_op_q;
   assign calc_a     = calc_a_q;
   assign calc_b     = calc_b_q;
   assign rsp_r      = rsp_r_q;
   assign rsp_ovf    = rsp_ovf_q;
   assign acc        = acc_q;
   assign ovf_sticky = sticky_q;
   assign op_count   = cnt_q;
   assign dbg_state  = state_q;

endmodule
